// File: rtl/hreg_pkg.sv
// Shared types and constants for the Hamming-register access controller.
// HREG_ACCESS_CTRL_SCRUB_EN enables the pre-sample SETTLE cycle for READ/SHIFT_OUT.
package hreg_pkg;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'b00,
        OP_READ      = 2'b01,
        OP_SHIFT_IN  = 2'b10,
        OP_SHIFT_OUT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

    localparam logic [1:0] MODE_SISO_R = 2'b00;
    localparam logic [1:0] MODE_SISO_L = 2'b01;
    localparam logic [1:0] MODE_PISO   = 2'b10;
    localparam logic [1:0] MODE_PIPO   = 2'b11;

`ifdef HREG_ACCESS_CTRL_SCRUB_EN
    localparam bit SCRUB_EN = 1'b1;
`else
    localparam bit SCRUB_EN = 1'b0;
`endif

endpackage

// File: rtl/hreg_access_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            valid_o
);

    logic [IDW:0]   cand_s;
    logic [IDW-1:0] cand_w_s;
    logic           hit_s;

    // Scan candidates in pointer order; the first hit locks the result.
    always_comb begin
        gnt_o    = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        cand_s   = '0;
        cand_w_s = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s   = {1'b0, ptr_i} + (IDW+1)'(i);
            cand_s   = (cand_s >= (IDW+1)'(NREQ)) ? cand_s - (IDW+1)'(NREQ) : cand_s;
            cand_w_s = cand_s[IDW-1:0];
            hit_s    = req_i[cand_w_s] & ~valid_o;
            gnt_o[cand_w_s] = gnt_o[cand_w_s] | hit_s;
            idx_o    = hit_s ? cand_w_s : idx_o;
            valid_o  = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/hreg_access_ctrl.sv
// Round-robin sequencer sharing one ECC shift-register datapath among NREQ requesters.
// Define HREG_ACCESS_CTRL_SCRUB_EN to insert a SETTLE cycle before READ/SHIFT_OUT.
module hreg_access_ctrl
    import hreg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int LENW  = $clog2(WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [2*NREQ-1:0]      op,
    input  logic [WIDTH*NREQ-1:0]  wdata,
    input  logic [LENW*NREQ-1:0]   len,
    output logic [NREQ-1:0]        gnt,
    output logic                   done,
    output logic [$clog2(NREQ)-1:0] done_id,
    output logic [WIDTH-1:0]       rdata,
    output logic                   busy,
    output logic                   reg_enable,
    output logic [1:0]             reg_mode,
    output logic                   reg_load,
    output logic                   reg_serial_in,
    output logic [WIDTH-1:0]       reg_parallel_in,
    input  logic                   reg_serial_out,
    input  logic [WIDTH-1:0]       reg_parallel_out
);

    localparam int IDW  = $clog2(NREQ);
    localparam int CNTW = $clog2(WIDTH);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [IDW-1:0]   ptr_q, ptr_d, id_q, id_d, done_id_q, done_id_d;
    logic [WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d, pin_q, pin_d;
    logic [LENW-1:0]  n_q, n_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             done_q, done_d, en_q, en_d, load_q, load_d, sin_q, sin_d;
    logic [1:0]       mode_q, mode_d;

    logic [NREQ-1:0]  arb_gnt_s;
    logic [IDW-1:0]   arb_idx_s;
    logic             arb_valid_s, last_s;
    op_e              op_sel_s;
    logic [WIDTH-1:0] wdata_sel_s;
    logic [LENW-1:0]  len_sel_s, n_sel_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    assign op_sel_s    = op_e'(op[2*int'(arb_idx_s) +: 2]);
    assign wdata_sel_s = wdata[WIDTH*int'(arb_idx_s) +: WIDTH];
    assign len_sel_s   = len[LENW*int'(arb_idx_s) +: LENW];
    // Zero encodes a full-width shift; oversized counts saturate at WIDTH.
    assign n_sel_s     = ((len_sel_s == '0) || (len_sel_s > LENW'(WIDTH))) ? LENW'(WIDTH) : len_sel_s;
    assign last_s      = (LENW'(cnt_q) == (n_q - LENW'(1)));

    assign gnt             = (state_q == ST_IDLE) ? arb_gnt_s : '0;
    assign busy            = (state_q != ST_IDLE) || arb_valid_s;
    assign done            = done_q;
    assign done_id         = done_id_q;
    assign rdata           = rdata_q;
    assign reg_enable      = en_q;
    assign reg_mode        = mode_q;
    assign reg_load        = load_q;
    assign reg_serial_in   = sin_q;
    assign reg_parallel_in = pin_q;

    // Next-state, command capture and datapath drive for the following cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    op_d    = op_sel_s;
                    wdata_d = wdata_sel_s;
                    n_d     = n_sel_s;
                    cnt_d   = '0;
                    id_d    = arb_idx_s;
                    ptr_d   = (arb_idx_s == IDW'(NREQ-1)) ? '0 : arb_idx_s + IDW'(1);
                    if (op_sel_s == OP_SHIFT_OUT) begin
                        for (int i = 0; i < WIDTH; i++) begin
                            rdata_d[i] = rdata_q[i] & (LENW'(i) < n_sel_s);
                        end
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = (SCRUB_EN && ((op_sel_s == OP_READ) || (op_sel_s == OP_SHIFT_OUT)))
                              ? ST_SETTLE : ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: state_d = ST_EXEC;
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD: state_d = ST_DONE;
                    OP_READ: begin
                        rdata_d = reg_parallel_out;
                        state_d = ST_DONE;
                    end
                    OP_SHIFT_IN, OP_SHIFT_OUT: begin
                        rdata_d[cnt_q] = (op_q == OP_SHIFT_OUT) ? reg_serial_out : rdata_q[cnt_q];
                        if (last_s) begin
                            state_d = ST_DONE;
                        end else begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        en_d   = 1'b0;
        mode_d = MODE_PIPO;
        load_d = 1'b0;
        sin_d  = 1'b0;
        pin_d  = pin_q;
        if (state_d == ST_EXEC) begin
            case (op_d)
                OP_LOAD: begin
                    en_d   = 1'b1;
                    load_d = 1'b1;
                    pin_d  = wdata_d;
                end
                OP_READ: en_d = 1'b0;
                OP_SHIFT_IN: begin
                    en_d   = 1'b1;
                    mode_d = MODE_SISO_R;
                    sin_d  = wdata_d[cnt_d];
                end
                OP_SHIFT_OUT: begin
                    en_d   = 1'b1;
                    mode_d = MODE_PISO;
                end
                default: en_d = 1'b0;
            endcase
        end else begin
            en_d = 1'b0;
        end
        done_d    = (state_d == ST_DONE);
        done_id_d = done_d ? id_q : done_id_q;
    end

    // State, command and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            op_q      <= OP_LOAD;
            wdata_q   <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            en_q      <= 1'b0;
            mode_q    <= MODE_PIPO;
            load_q    <= 1'b0;
            sin_q     <= 1'b0;
            pin_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            op_q      <= op_d;
            wdata_q   <= wdata_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            load_q    <= load_d;
            sin_q     <= sin_d;
            pin_q     <= pin_d;
        end
    end

endmodule
